// File: rtl/wheel_encoder_uc.sv
// wheel_encoder_uc
// Control unit for the wheel-speed datapath. Decodes the raw quadrature
// channels into single-cycle CW/CCW count pulses and sequences the periodic
// measurement window (clear, count, register, done). Also flags illegal
// quadrature transitions and windows closed early by pulse saturation.
//
// Parameters
//   JANELA      window length in clock cycles (>= 2)
//   MAX_PULSOS  valid transitions accepted per window before it closes early
//
// Ports
//   clock_i      system clock, rising edge
//   reset_i      asynchronous active-high reset
//   iniciar_i    level, starts measuring from INICIAL
//   continuo_i   level, 1 = chain windows, 0 = return to INICIAL after PRONTO
//   parar_i      level, synchronous abort to INICIAL
//   enc_a_i      raw encoder channel A (asynchronous)
//   enc_b_i      raw encoder channel B (asynchronous)
//   zera_o       one-cycle clear strobe for the datapath counters
//   conta_cw_o   one-cycle clockwise count pulse
//   conta_ccw_o  one-cycle counter-clockwise count pulse
//   registra_o   one-cycle output-register load strobe
//   pronto_o     one-cycle window-complete pulse
//   saturado_o   window closed by MAX_PULSOS, held until the next clear
//   erro_quad_o  sticky illegal-transition flag
//   db_estado_o  current state code
module wheel_encoder_uc #(
  parameter int JANELA     = 50000,
  parameter int MAX_PULSOS = 7
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       iniciar_i,
  input  logic       continuo_i,
  input  logic       parar_i,
  input  logic       enc_a_i,
  input  logic       enc_b_i,
  output logic       zera_o,
  output logic       conta_cw_o,
  output logic       conta_ccw_o,
  output logic       registra_o,
  output logic       pronto_o,
  output logic       saturado_o,
  output logic       erro_quad_o,
  output logic [3:0] db_estado_o
);

  localparam int WIN_W   = $clog2(JANELA);
  localparam int PULSE_W = $clog2(MAX_PULSOS + 1);
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(JANELA - 1);
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(MAX_PULSOS);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ZERA     = 4'd1,
    MEDINDO  = 4'd2,
    REGISTRA = 4'd3,
    PRONTO   = 4'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync1_q, sync2_q, prev_ab_q;
  logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
  logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic                 zera_q, zera_d;
  logic                 cw_q, cw_d;
  logic                 ccw_q, ccw_d;
  logic                 registra_q, registra_d;
  logic                 pronto_q, pronto_d;
  logic                 sat_q, sat_d;
  logic                 erro_q, erro_d;
  logic                 step_cw, step_ccw, step_bad;
  logic                 count_en;

  // Encoder synchronizer: two flops per channel, then the previous-value
  // register the decoder compares against.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      prev_ab_q <= 2'b00;
    end else begin
      sync1_q   <= {enc_a_i, enc_b_i};
      sync2_q   <= sync1_q;
      prev_ab_q <= sync2_q;
    end
  end

  // Gray-sequence decode of {prev, curr}. A change in both bits at once
  // means a step was missed, so no direction can be inferred.
  always_comb begin
    step_cw  = 1'b0;
    step_ccw = 1'b0;
    step_bad = 1'b0;
    case ({prev_ab_q, sync2_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_cw  = 1'b1;
      4'b0100, 4'b1101, 4'b1011, 4'b0010: step_ccw = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: step_bad = 1'b1;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= INICIAL;
    else         state_q <= state_d;
  end

  // Next-state logic. The saturation exit uses the count already reached,
  // so the final pulse is out one cycle before registra.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:  if (iniciar_i) state_d = ZERA;
      ZERA:     state_d = MEDINDO;
      MEDINDO:  if ((win_cnt_q == WIN_LAST) || (pulse_cnt_q == PULSE_MAX))
                  state_d = REGISTRA;
      REGISTRA: state_d = PRONTO;
      PRONTO:   state_d = continuo_i ? ZERA : INICIAL;
      default:  state_d = INICIAL;
    endcase
    if (parar_i) state_d = INICIAL;
  end

  // Output and counter next-state logic. Pulses are only accepted while the
  // machine stays in MEDINDO across the edge, which keeps the last count
  // pulse clear of registra and suppresses pulses on an abort.
  always_comb begin
    count_en    = (state_q == MEDINDO) && (state_d == MEDINDO);
    zera_d      = (state_d == ZERA);
    registra_d  = (state_d == REGISTRA);
    pronto_d    = (state_d == PRONTO);
    cw_d        = count_en & step_cw;
    ccw_d       = count_en & step_ccw;
    win_cnt_d   = win_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    sat_d       = sat_q;
    erro_d      = erro_q;

    if (state_q == ZERA) begin
      win_cnt_d   = '0;
      pulse_cnt_d = '0;
      sat_d       = 1'b0;
    end else if (state_q == MEDINDO) begin
      if (win_cnt_q != WIN_LAST) win_cnt_d = win_cnt_q + 1'b1;
      if (count_en && (step_cw || step_ccw)) pulse_cnt_d = pulse_cnt_q + 1'b1;
      if ((state_d == REGISTRA) && (pulse_cnt_q == PULSE_MAX)) sat_d = 1'b1;
    end

    if ((state_q == INICIAL) && (state_d == ZERA)) erro_d = 1'b0;
    if (step_bad) erro_d = 1'b1;
  end

  // Output and counter registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      win_cnt_q   <= '0;
      pulse_cnt_q <= '0;
      zera_q      <= 1'b0;
      cw_q        <= 1'b0;
      ccw_q       <= 1'b0;
      registra_q  <= 1'b0;
      pronto_q    <= 1'b0;
      sat_q       <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      zera_q      <= zera_d;
      cw_q        <= cw_d;
      ccw_q       <= ccw_d;
      registra_q  <= registra_d;
      pronto_q    <= pronto_d;
      sat_q       <= sat_d;
      erro_q      <= erro_d;
    end
  end

  assign zera_o      = zera_q;
  assign conta_cw_o  = cw_q;
  assign conta_ccw_o = ccw_q;
  assign registra_o  = registra_q;
  assign pronto_o    = pronto_q;
  assign saturado_o  = sat_q;
  assign erro_quad_o = erro_q;
  assign db_estado_o = state_q;

endmodule

// File: tb/tb_wheel_encoder_uc.sv
// Testbench for wheel_encoder_uc: directed scenarios followed by randomized
// stimulus, every cycle compared against a window-position reference model.
module tb_wheel_encoder_uc;

  localparam int JANELA     = 20;
  localparam int MAX_PULSOS = 7;

  logic       clk, rst;
  logic       iniciar, continuo, parar, enc_a, enc_b;
  logic       zera_o, conta_cw_o, conta_ccw_o, registra_o, pronto_o;
  logic       saturado_o, erro_quad_o;
  logic [3:0] db_estado_o;

  wheel_encoder_uc #(.JANELA(JANELA), .MAX_PULSOS(MAX_PULSOS)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .iniciar_i   (iniciar),
    .continuo_i  (continuo),
    .parar_i     (parar),
    .enc_a_i     (enc_a),
    .enc_b_i     (enc_b),
    .zera_o      (zera_o),
    .conta_cw_o  (conta_cw_o),
    .conta_ccw_o (conta_ccw_o),
    .registra_o  (registra_o),
    .pronto_o    (pronto_o),
    .saturado_o  (saturado_o),
    .erro_quad_o (erro_quad_o),
    .db_estado_o (db_estado_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Quadrature tables: clockwise runs 00,01,11,10; counter-clockwise reverses it.
  function automatic logic [1:0] cw_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_next(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Reference model. Window position: -1 idle, 0 clearing, 1..JANELA the
  // measuring cycles, JANELA+1 register, JANELA+2 done. Pin samples are kept
  // in a short history; a pulse decision at edge n looks at the pins sampled
  // at edges n-3 and n-2 (two synchronizer stages plus the previous value).
  int         m_pos;
  int         m_pulses;
  bit         m_sat, m_err;
  logic [1:0] hist[$];
  bit         e_zera, e_cw, e_ccw, e_reg, e_pr;
  logic [3:0] e_db;

  task automatic model_reset();
    m_pos = -1; m_pulses = 0; m_sat = 0; m_err = 0;
    hist = {2'b00, 2'b00, 2'b00};
    e_zera = 0; e_cw = 0; e_ccw = 0; e_reg = 0; e_pr = 0; e_db = 4'd0;
  endtask

  function automatic bit measuring(input int p);
    return (p >= 1) && (p <= JANELA);
  endfunction

  task automatic model_step();
    logic [1:0] cur, prv;
    int         old_pos, new_pos;
    bit         emit;
    if (rst) begin
      model_reset();
      return;
    end
    hist.push_back({enc_a, enc_b});
    if (hist.size() > 4) void'(hist.pop_front());
    prv = hist[0];
    cur = hist[1];
    old_pos = m_pos;
    if (parar)                     new_pos = -1;
    else if (old_pos == -1)        new_pos = iniciar ? 0 : -1;
    else if (old_pos == 0)         new_pos = 1;
    else if (measuring(old_pos)) begin
      if (old_pos == JANELA || m_pulses == MAX_PULSOS) begin
        new_pos = JANELA + 1;
        if (m_pulses == MAX_PULSOS) m_sat = 1;
      end else new_pos = old_pos + 1;
    end
    else if (old_pos == JANELA + 1) new_pos = JANELA + 2;
    else                            new_pos = continuo ? 0 : -1;

    if (old_pos == 0) begin
      m_pulses = 0;
      m_sat    = 0;
    end
    emit  = measuring(old_pos) && measuring(new_pos);
    e_cw  = emit && (cur == cw_next(prv));
    e_ccw = emit && (cur == ccw_next(prv));
    if (e_cw || e_ccw) m_pulses++;
    if ((cur ^ prv) == 2'b11)                m_err = 1;
    else if (old_pos == -1 && new_pos == 0)  m_err = 0;

    m_pos  = new_pos;
    e_zera = (m_pos == 0);
    e_reg  = (m_pos == JANELA + 1);
    e_pr   = (m_pos == JANELA + 2);
    if (m_pos < 0)                 e_db = 4'd0;
    else if (m_pos == 0)           e_db = 4'd1;
    else if (m_pos <= JANELA)      e_db = 4'd2;
    else if (m_pos == JANELA + 1)  e_db = 4'd3;
    else                           e_db = 4'd4;
  endtask

  // Event bookkeeping for the directed scenarios
  int cyc = 0;
  int n_cw = 0, n_ccw = 0, n_reg = 0, n_pr = 0;
  int last_ccw_cyc = -1, reg_cyc = -1;
  bit sat_at_reg = 0;
  logic [1:0] ab = 2'b00;

  task automatic clear_counts();
    n_cw = 0; n_ccw = 0; n_reg = 0; n_pr = 0;
    last_ccw_cyc = -1; reg_cyc = -1; sat_at_reg = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    chk("zera",      zera_o,      e_zera);
    chk("conta_cw",  conta_cw_o,  e_cw);
    chk("conta_ccw", conta_ccw_o, e_ccw);
    chk("registra",  registra_o,  e_reg);
    chk("pronto",    pronto_o,    e_pr);
    chk("saturado",  saturado_o,  m_sat);
    chk("erro_quad", erro_quad_o, m_err);
    chk("db_estado", db_estado_o, e_db);
    if (conta_cw_o) n_cw++;
    if (conta_ccw_o) begin n_ccw++; last_ccw_cyc = cyc; end
    if (registra_o) begin
      n_reg++;
      if (reg_cyc < 0) begin reg_cyc = cyc; sat_at_reg = saturado_o; end
    end
    if (pronto_o) n_pr++;
  endtask

  task automatic set_ab(input logic [1:0] v);
    ab = v;
    enc_a = v[1];
    enc_b = v[0];
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * JANELA && m_pos != -1; i++) tick();
    chk("idle_reached", db_estado_o, 4'd0);
  endtask

  task automatic start_window();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  // Asynchronous reset between edges; outputs must drop before the next edge.
  task automatic arst();
    #2 rst = 1'b1;
    #1;
    chk("arst_zera",     zera_o,      1'b0);
    chk("arst_cw",       conta_cw_o,  1'b0);
    chk("arst_ccw",      conta_ccw_o, 1'b0);
    chk("arst_registra", registra_o,  1'b0);
    chk("arst_pronto",   pronto_o,    1'b0);
    chk("arst_saturado", saturado_o,  1'b0);
    chk("arst_erro",     erro_quad_o, 1'b0);
    chk("arst_db",       db_estado_o, 4'd0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_z1, t_z2, t_reg, t_pr, start, r;
    rst = 1'b1; iniciar = 1'b0; continuo = 1'b0; parar = 1'b0;
    enc_a = 1'b0; enc_b = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_db", db_estado_o, 4'd0);
    rst = 1'b0;

    // Continuous windows, no encoder activity: window cadence
    t_z1 = -1; t_z2 = -1; t_reg = -1; t_pr = -1;
    continuo = 1'b1;
    iniciar  = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      iniciar = 1'b0;
      if (zera_o) begin
        if (t_z1 < 0) t_z1 = i; else if (t_z2 < 0) t_z2 = i;
      end
      if (registra_o && t_reg < 0) t_reg = i;
      if (pronto_o && t_pr < 0) t_pr = i;
    end
    chk("cad_zera1",    t_z1,  1);
    chk("cad_registra", t_reg, JANELA + 2);
    chk("cad_pronto",   t_pr,  JANELA + 3);
    chk("cad_zera2",    t_z2,  JANELA + 4);
    continuo = 1'b0;
    wait_idle();

    // Three CW steps four cycles apart, pulse three edges after each change
    start_window();
    clear_counts();
    for (int s = 0; s < 3; s++) begin
      set_ab(cw_next(ab));
      tick();
      tick();
      chk("cw_early", conta_cw_o, 1'b0);
      tick();
      chk("cw_latency", conta_cw_o, 1'b1);
      tick();
    end
    chk("cw_count",  n_cw,  3);
    chk("cw_no_ccw", n_ccw, 0);
    wait_idle();

    // Ten CCW steps in one window: saturation closes it after the 7th
    start_window();
    clear_counts();
    start = cyc;
    for (int s = 0; s < 10; s++) begin
      set_ab(ccw_next(ab));
      tick();
      tick();
    end
    chk("sat_count",      n_ccw, MAX_PULSOS);
    chk("sat_flag",       sat_at_reg, 1'b1);
    chk("sat_reg_after",  reg_cyc - last_ccw_cyc, 1);
    chk("sat_early",      (reg_cyc - start) < JANELA, 1'b1);
    wait_idle();

    // Illegal double-bit change: sticky error, no pulse, cleared on restart
    start_window();
    clear_counts();
    set_ab(ab ^ 2'b11);
    tick(); tick(); tick();
    chk("bad_err_set", erro_quad_o, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("bad_err_held", erro_quad_o, 1'b1);
    chk("bad_no_pulse", n_cw + n_ccw, 0);
    wait_idle();
    chk("bad_err_idle", erro_quad_o, 1'b1);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("bad_err_clear", erro_quad_o, 1'b0);
    wait_idle();

    // Abort mid-window: straight to INICIAL, no register/done, no pulses after
    start_window();
    tick(); tick(); tick();
    parar = 1'b1;
    tick();
    parar = 1'b0;
    chk("parar_db", db_estado_o, 4'd0);
    clear_counts();
    for (int s = 0; s < 3; s++) begin
      set_ab(cw_next(ab));
      repeat (4) tick();
    end
    repeat (JANELA) tick();
    chk("parar_no_cw",       n_cw,  0);
    chk("parar_no_registra", n_reg, 0);
    chk("parar_no_pronto",   n_pr,  0);

    // Asynchronous reset mid-window with a pulse in flight
    start_window();
    repeat (4) tick();
    set_ab(cw_next(ab));
    tick();
    tick();
    arst();
    tick();
    chk("arst_after_db", db_estado_o, 4'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      iniciar = (r < 70);
      if ($urandom_range(0, 15) == 0) continuo = ~continuo;
      parar = ($urandom_range(0, 63) == 0);
      r = $urandom_range(0, 15);
      if (r < 5)       set_ab(cw_next(ab));
      else if (r < 9)  set_ab(ccw_next(ab));
      else if (r == 9) set_ab(ab ^ 2'b11);
      if ($urandom_range(0, 499) == 0) arst();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
